// File: rtl/aes128_iter_encryptor.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides.
// Optional AES_OUT_MASK_EN: zero ciphertext_o/tag_o whenever cipher_valid_o is low.
module aes128_iter_encryptor #(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [127:0]     key_i,
  input  logic             key_valid_i,
  input  logic [127:0]     plaintext_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [127:0]     ciphertext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             cipher_valid_o,
  input  logic             cipher_ready_i,
  output logic             busy_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_iter_encryptor: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic               en_q;
  logic [127:0]       key_q, st_q, rk_q, ct_q;
  logic [3:0]         rnd_q;
  logic [7:0]         rcon_q;
  logic [TAG_W-1:0]   tag_q, tag_out_q;
  logic               valid_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the FIPS-197 affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, sq, b;
    r  = 8'h01;
    sq = x;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st_nx, rk_nx, key_eff;
  logic [7:0]   rcon_nx;
  logic         last_rnd, accept;

  always_comb begin
    st_nx   = st_q;
    rk_nx   = rk_q;
    rcon_nx = rcon_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      rk_nx   = key_step(rk_nx, rcon_nx);
      rcon_nx = xtime(rcon_nx);
      st_nx   = shift_rows(sub_bytes(st_nx));
      if (32'(rnd_q) + i != 32'd10) st_nx = mix_columns(st_nx);
      st_nx = st_nx ^ rk_nx;
    end
  end

  assign last_rnd     = (32'(rnd_q) + UNROLL == 32'd11);
  assign data_ready_o = en_q && ((state_q == S_IDLE) || (state_q == S_DONE && cipher_ready_i));
  assign accept       = data_valid_i && data_ready_o;
  // A key strobe in IDLE applies to a block accepted in the same cycle.
  assign key_eff      = (state_q == S_IDLE && key_valid_i) ? key_i : key_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      key_q     <= '0;
      st_q      <= '0;
      rk_q      <= '0;
      ct_q      <= '0;
      rnd_q     <= '0;
      rcon_q    <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (state_q == S_IDLE && key_valid_i) key_q <= key_i;
      case (state_q)
        S_RUN: begin
          st_q   <= st_nx;
          rk_q   <= rk_nx;
          rcon_q <= rcon_nx;
          rnd_q  <= rnd_q + 4'(UNROLL);
          if (last_rnd) begin
            ct_q      <= st_nx;
            tag_out_q <= tag_q;
            valid_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (cipher_ready_i) begin
            valid_q <= 1'b0;
`ifdef AES_OUT_MASK_EN
            ct_q      <= '0;
            tag_out_q <= '0;
`endif
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
      if (accept) begin
        st_q    <= plaintext_i ^ key_eff;
        rk_q    <= key_eff;
        rnd_q   <= 4'd1;
        rcon_q  <= 8'h01;
        tag_q   <= tag_i;
        state_q <= S_RUN;
      end
    end
  end

`ifdef AES_OUT_MASK_EN
  assign ciphertext_o = valid_q ? ct_q : '0;
  assign tag_o        = valid_q ? tag_out_q : '0;
`else
  assign ciphertext_o = ct_q;
  assign tag_o        = tag_out_q;
`endif
  assign cipher_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes128_iter_encryptor.sv
// Scoreboard bench for aes128_iter_encryptor: UNROLL=1 main instance plus UNROLL 2/5/10 sweep.
module tb_aes128_iter_encryptor;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key = '0, pt = '0;
  logic [3:0]   tag = '0;
  logic         key_valid = 1'b0, data_valid = 1'b0, cipher_ready = 1'b1;
  logic         data_ready, cipher_valid, busy;
  logic [127:0] ciphertext;
  logic [3:0]   tag_out;

  logic         sw_kv = 1'b0, sw_dv = 1'b0;
  logic         sw_ready [3];
  logic [127:0] sw_ct [3];
  logic [3:0]   sw_tag [3];
  logic         sw_cv [3];
  logic         sw_busy [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] ct;
    logic [3:0]   tag;
    int           acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aes128_iter_encryptor #(.UNROLL(1), .TAG_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key), .key_valid_i(key_valid),
    .plaintext_i(pt), .tag_i(tag), .data_valid_i(data_valid), .data_ready_o(data_ready),
    .ciphertext_o(ciphertext), .tag_o(tag_out), .cipher_valid_o(cipher_valid),
    .cipher_ready_i(cipher_ready), .busy_o(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    aes128_iter_encryptor #(.UNROLL(g == 0 ? 2 : (g == 1 ? 5 : 10)), .TAG_W(4)) u_sw (
      .clk_i(clk), .rst_n_i(rst_n), .key_i(key), .key_valid_i(sw_kv),
      .plaintext_i(pt), .tag_i(tag), .data_valid_i(sw_dv), .data_ready_o(sw_ready[g]),
      .ciphertext_o(sw_ct[g]), .tag_o(sw_tag[g]), .cipher_valid_o(sw_cv[g]),
      .cipher_ready_i(1'b1), .busy_o(sw_busy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: latency on rising valid, data on handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cipher_valid && !prev_v) begin
      if (sb.size() == 0) fail_now("latency_no_expect");
      else check("latency", 128'(cyc - sb[0].acc), 128'd10);
    end
    if (rst_n && cipher_valid && cipher_ready) begin
      if (sb.size() == 0) fail_now("unexpected_output");
      else begin
        e = sb.pop_front();
        check("ct", ciphertext, e.ct);
        check("tag", 128'(tag_out), 128'(e.tag));
      end
    end
    prev_v = cipher_valid;
  end

  // Called right after a posedge; returns at posedge+1 of the accept edge.
  task automatic send(input logic [127:0] k, input logic kv, input logic [127:0] p,
                      input logic [3:0] t, input logic [127:0] exp_ct);
    logic acc;
    exp_t e;
    key = k; key_valid = kv; pt = p; tag = t; data_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk) acc = data_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        e.ct = exp_ct; e.tag = t; e.acc = cyc;
        sb.push_back(e);
        data_valid = 1'b0; key_valid = 1'b0;
        return;
      end
    end
    data_valid = 1'b0; key_valid = 1'b0;
    fail_now("accept_timeout");
  endtask

  // Returns at the negedge after the final handshake.
  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    fail_now("idle_timeout");
  endtask

  initial begin
    logic [127:0] held_ct;
    logic [3:0]   held_tag;
    logic         seen [3];
    int           got;

    #2;
    check("rst_ct", ciphertext, '0);
    check("rst_valid", 128'(cipher_valid), '0);
    check("rst_busy", 128'(busy), '0);
    check("rst_ready", 128'(data_ready), '0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 128'(data_ready), 128'd1);

    // UNROLL sweep on the B vector.
    key = KEY_B; pt = PT_B; tag = 4'h9; sw_kv = 1'b1; sw_dv = 1'b1;
    @(posedge clk); #1;
    sw_kv = 1'b0; sw_dv = 1'b0;
    for (int g = 0; g < 3; g++) seen[g] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        if (sw_cv[g] && !seen[g]) begin
          seen[g] = 1'b1;
          check("sweep_latency", 128'(k), (g == 0) ? 128'd5 : ((g == 1) ? 128'd2 : 128'd1));
          check("sweep_ct", sw_ct[g], CT_B);
          check("sweep_tag", 128'(sw_tag[g]), 128'h9);
        end
      end
    end
    for (int g = 0; g < 3; g++) if (!seen[g]) fail_now("sweep_no_output");

    // C.1 with key loaded alongside the block.
    @(posedge clk); #1;
    send(KEY_C1, 1'b1, PT_C1, 4'h5, CT_C1);
    wait_idle();
`ifdef AES_OUT_MASK_EN
    check("ct_after_handshake", ciphertext, '0);
`else
    check("ct_after_handshake", ciphertext, CT_C1);
`endif

    // B with key reload in IDLE; output before completion.
    @(posedge clk); #1;
    send(KEY_B, 1'b1, PT_B, 4'hA, CT_B);
    @(negedge clk);
`ifdef AES_OUT_MASK_EN
    check("ct_during_run", ciphertext, '0);
`else
    check("ct_during_run", ciphertext, CT_C1);
`endif
    check("busy_run", 128'(busy), 128'd1);
    wait_idle();

    // Back-pressure.
    @(posedge clk); #1;
    cipher_ready = 1'b0;
    send(KEY_C1, 1'b1, PT_C1, 4'h3, CT_C1);
    got = 0;
    for (int n = 0; n < 30 && got == 0; n++) begin
      @(negedge clk);
      if (cipher_valid) got = 1;
    end
    if (got == 0) fail_now("bp_valid_timeout");
    held_ct = ciphertext;
    held_tag = tag_out;
    check("bp_ct_value", held_ct, CT_C1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_ct_stable", ciphertext, held_ct);
      check("bp_tag_stable", 128'(tag_out), 128'(held_tag));
      check("bp_ready_low", 128'(data_ready), '0);
      check("bp_busy", 128'(busy), 128'd1);
    end
    // Handshake and new accept on the same edge; key strobe in DONE is ignored.
    @(posedge clk); #1;
    cipher_ready = 1'b1;
    send(KEY_B, 1'b1, PT_C1, 4'h7, CT_C1);
    wait_idle();

    // Key strobe during RUN must not affect the block or the stored key.
    @(posedge clk); #1;
    send(KEY_C1, 1'b1, PT_C1, 4'h1, CT_C1);
    repeat (3) @(posedge clk);
    #1 key = KEY_B; key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    send(KEY_B, 1'b0, PT_C1, 4'h2, CT_C1);
    wait_idle();
    @(posedge clk); #1;
    send(KEY_B, 1'b1, PT_B, 4'h4, CT_B);
    wait_idle();
    @(posedge clk); #1;
    send(KEY_C1, 1'b0, PT_B, 4'h6, CT_B);
    wait_idle();

    // Async reset mid-RUN.
    @(posedge clk); #1;
    send(KEY_C1, 1'b1, PT_C1, 4'hF, CT_C1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ct", ciphertext, '0);
    check("arst_tag", 128'(tag_out), '0);
    check("arst_valid", 128'(cipher_valid), '0);
    check("arst_busy", 128'(busy), '0);
    check("arst_ready", 128'(data_ready), '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_arst", 128'(data_ready), 128'd1);
    send(KEY_C1, 1'b1, PT_C1, 4'h5, CT_C1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
